ssio_sdr_out_diff_tx: RTL and testbench
=======================================

// Module: ssio_sdr_out_diff_tx
// PURPOSE
// - Source-synchronous SDR differential transmitter; the send side of the differential SDR input path.
// - Accepts words on a valid/ready stream and drives registered data plus one control lane.
// - Forwards a centre-aligned clock on a differential pair, with the data lanes also differential.
// - Inserts a training pattern after reset and on request, and an idle pattern when no data is offered.
// PARAMETERS
// - TARGET        "GENERIC"  "SIM", "GENERIC", "XILINX" or "ALTERA"; selects the output primitives.
// - IODDR_STYLE   "IODDR"    "IODDR" or "IODDR2"; Xilinx clock-forwarding primitive.
// - WIDTH         4          data lanes; control lane is extra.
// - TRAIN_CYCLES  64         training length in clk cycles; must be >= 1.
// - TRAIN_PATTERN 4'hA       fixed training word (WIDTH bits).
// - IDLE_PATTERN  4'h0       data word driven while idle in ACTIVE.
// PORTS
// - clk           in   1        transmit clock; all logic is on the rising edge.
// - rst_n         in   1        synchronous reset, active low.
// - s_data        in   WIDTH    word to send.
// - s_valid       in   1        s_data is valid.
// - s_ready       out  1        word is accepted on s_valid && s_ready.
// - train_req     in   1        single-cycle pulse: start or restart training.
// - train_active  out  1        high while in TRAIN.
// - output_clk_p  out  1        forwarded clock, positive leg.
// - output_clk_n  out  1        forwarded clock, negative leg.
// - output_q_p    out  WIDTH+1  lanes, positive legs; bit WIDTH is control (1 = data word).
// - output_q_n    out  WIDTH+1  lanes, negative legs.
// BEHAVIOUR
// - Reset (rst_n low at an edge):
//   - state <= TRAIN; counter <= 0; s_ready = 0; train_active = 1.
//   - Lane register <= {1'b0, IDLE_PATTERN}.
// - Reset mid-operation: any word not yet accepted is not sent; a word accepted in the reset cycle is discarded.
// - States:
//   - TRAIN: counter increments each cycle; lanes <= {0, training word}.
//     At counter == TRAIN_CYCLES-1, go to ACTIVE and clear the counter.
//   - ACTIVE: s_ready = 1 unless train_req is high this cycle.
//     Transfer: lanes <= {1, s_data}. No transfer: lanes <= {0, IDLE_PATTERN}.
// - train_req high in ACTIVE: s_ready is 0 that cycle; TRAIN starts at the next cycle with the counter at 0.
// - train_req high in TRAIN: counter restarts at 0, so the full TRAIN_CYCLES runs from that point.
// - train_req coinciding with the final TRAIN cycle: state stays TRAIN and the counter restarts.
// - Latency: a word accepted at edge N appears on the lanes after edge N; one register stage, no bubbles.
// - Back-to-back words are sent on consecutive cycles.
// - s_ready and train_active are combinational from state and train_req.
// - Counter width is $clog2(TRAIN_CYCLES+1); the counter never wraps.
// - Clock forwarding:
//   - XILINX: ODDR/ODDR2 with D1=0, D2=1, so the clock is inverted with its edge centred in the data eye.
//   - Other targets: output_clk_p = ~clk.
// - Differential buffers:
//   - XILINX: OBUFDS on every clock and lane pair.
//   - ALTERA: ALT_OUTBUF_DIFF on every clock and lane pair.
//   - GENERIC/SIM: _n = ~_p.
// CONFIGURATION
// - SSIO_SDR_TX_PRBS_EN defined:
//   - Training word is taken from a PRBS7 generator (x^7+x^6+1).
//   - Lane n = prbs[n % 7]; the generator advances once per TRAIN cycle.
//   - Seed is 7'h7F on reset and at every entry or restart of TRAIN.
//   - TRAIN_PATTERN is ignored.
// - SSIO_SDR_TX_PRBS_EN undefined: training word = TRAIN_PATTERN every cycle; no PRBS logic is built.
// TESTING
// - Release rst_n -> train_active=1 for exactly 64 cycles with q_p=5'h0A; then s_ready=1 and q_p=5'h00.
// - ACTIVE, s_data 4'h3,4'h5,4'hC on 3 consecutive valid cycles -> q_p=5'h13,5'h15,5'h1C on the next 3 cycles, then 5'h00.
// - train_req pulse with s_valid=1 -> s_ready=0 that cycle; word not sent; 64 training cycles; word sent first after training.
// - train_req again at training cycle 30 -> training lasts 30+64 cycles in total.
// - rst_n low for 1 cycle mid-burst -> next q_p=5'h00; training restarts; no partial word is emitted.
// - PRBS_EN, WIDTH=4 -> first training words match the PRBS7 reference model from seed 7'h7F; GENERIC: q_n == ~q_p always.

Source files
------------

// File: rtl/ssio_sdr_out_diff_tx.sv
// Source-synchronous SDR differential transmitter.
// Accepts words on a valid/ready stream and drives them on registered lanes. The
// top lane bit is a control flag that marks data words. A centre-aligned clock is
// forwarded with the lanes. The block sends a training pattern after reset and on
// request, and an idle pattern when no word is offered.
// Optional feature: define SSIO_SDR_TX_PRBS_EN to take the training word from a
// PRBS7 generator (x^7+x^6+1, seed 7'h7F) instead of TRAIN_PATTERN.
// Vendor primitives (ODDR/ODDR2/OBUFDS/ALT_OUTBUF_DIFF) exist only inside vendor
// tool flows. They are therefore compiled only when SSIO_SDR_TX_VENDOR_PRIMS is
// defined. Without it, every TARGET uses the behavioural output stage.
module ssio_sdr_out_diff_tx #(
  parameter TARGET       = "GENERIC",
  parameter IODDR_STYLE  = "IODDR",
  parameter int WIDTH        = 4,
  parameter int TRAIN_CYCLES = 64,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'hA,
  parameter logic [WIDTH-1:0] IDLE_PATTERN  = 4'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             train_req,
  output logic             train_active,
  output logic             output_clk_p,
  output logic             output_clk_n,
  output logic [WIDTH:0]   output_q_p,
  output logic [WIDTH:0]   output_q_n
);

  localparam int CW = $clog2(TRAIN_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TRAIN_CYCLES - 1);

  typedef enum logic {TRAIN, ACTIVE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   lanes_q;
  logic [WIDTH-1:0] train_word;
  logic             xfer;

  assign s_ready      = (state_q == ACTIVE) && !train_req;
  assign train_active = (state_q == TRAIN);
  assign xfer         = s_valid && s_ready;

`ifdef SSIO_SDR_TX_PRBS_EN
  logic [6:0] prbs_q;
  logic [6:0] prbs_d;

  // Compute the next PRBS value. Reseed on every TRAIN entry or restart; advance once per TRAIN cycle.
  always_comb begin
    prbs_d = prbs_q;
    if (train_req) begin
      prbs_d = 7'h7F;
    end else if (state_q == TRAIN) begin
      prbs_d = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};
    end
  end

  // Hold the PRBS state, which is seeded from reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prbs_q <= 7'h7F;
    end else begin
      prbs_q <= prbs_d;
    end
  end

  // Map generator bits onto the lanes, repeating every seven lanes.
  always_comb begin
    train_word = '0;
    for (int n = 0; n < WIDTH; n++) begin
      train_word[n] = prbs_q[n % 7];
    end
  end
`else
  // Use the fixed training word.
  always_comb begin
    train_word = TRAIN_PATTERN;
  end
`endif

  // Run the TRAIN/ACTIVE sequencing and register the lane word for the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TRAIN;
      cnt_q   <= '0;
      lanes_q <= {1'b0, IDLE_PATTERN};
    end else begin
      case (state_q)
        TRAIN: begin
          lanes_q <= {1'b0, train_word};
          if (train_req) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_COUNT) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            lanes_q <= {1'b1, s_data};
          end else begin
            lanes_q <= {1'b0, IDLE_PATTERN};
          end
          if (train_req) begin
            state_q <= TRAIN;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= TRAIN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  generate
`ifdef SSIO_SDR_TX_VENDOR_PRIMS
    if (TARGET == "XILINX") begin : g_xilinx
      logic fwd_clk;
      if (IODDR_STYLE == "IODDR2") begin : g_oddr2
        ODDR2 u_clk_oddr (.Q(fwd_clk), .C0(clk), .C1(~clk), .CE(1'b1),
                          .D0(1'b0), .D1(1'b1), .R(1'b0), .S(1'b0));
      end else begin : g_oddr
        ODDR u_clk_oddr (.Q(fwd_clk), .C(clk), .CE(1'b1),
                         .D1(1'b0), .D2(1'b1), .R(1'b0), .S(1'b0));
      end
      OBUFDS u_clk_buf (.I(fwd_clk), .O(output_clk_p), .OB(output_clk_n));
      for (genvar i = 0; i <= WIDTH; i++) begin : g_lane
        OBUFDS u_lane_buf (.I(lanes_q[i]), .O(output_q_p[i]), .OB(output_q_n[i]));
      end
    end else if (TARGET == "ALTERA") begin : g_altera
      ALT_OUTBUF_DIFF u_clk_buf (.i(~clk), .o(output_clk_p), .obar(output_clk_n));
      for (genvar i = 0; i <= WIDTH; i++) begin : g_lane
        ALT_OUTBUF_DIFF u_lane_buf (.i(lanes_q[i]), .o(output_q_p[i]), .obar(output_q_n[i]));
      end
    end else begin : g_generic
      assign output_clk_p = ~clk;
      assign output_clk_n = clk;
      assign output_q_p   = lanes_q;
      assign output_q_n   = ~lanes_q;
    end
`else
    begin : g_generic
      assign output_clk_p = ~clk;
      assign output_clk_n = clk;
      assign output_q_p   = lanes_q;
      assign output_q_n   = ~lanes_q;
    end
`endif
  endgenerate

endmodule

// File: tb/tb_ssio_sdr_out_diff_tx.sv
// Testbench for ssio_sdr_out_diff_tx (default parameters, optional SSIO_SDR_TX_PRBS_EN).
module tb_ssio_sdr_out_diff_tx;

  localparam int TC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       train_req = 1'b0;
  logic       train_active;
  logic       output_clk_p, output_clk_n;
  logic [4:0] output_q_p, output_q_n;

  int checks = 0;
  int errors = 0;

  // Reference model: training cycles still to run (0 = sending), plus the expected lane word.
  int         trainLeft = TC;
  logic [4:0] expQ = 5'h00;
  logic [6:0] prbsModel = 7'h7F;

  typedef struct {
    logic       valid;
    logic [3:0] data;
    logic       req;
    logic [4:0] q;
    logic       ready;
  } vec_t;

  vec_t vecs[5];

  ssio_sdr_out_diff_tx dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .train_req(train_req), .train_active(train_active),
    .output_clk_p(output_clk_p), .output_clk_n(output_clk_n),
    .output_q_p(output_q_p), .output_q_n(output_q_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] trainWord();
`ifdef SSIO_SDR_TX_PRBS_EN
    return {prbsModel[3], prbsModel[2], prbsModel[1], prbsModel[0]};
`else
    return 4'hA;
`endif
  endfunction

  // Apply one cycle of inputs, check the combinational outputs, advance the model, and check the lanes.
  task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] d, input logic r,
                               output logic sawReady, output logic sawTrain);
    logic inTrain, expReady;
    @(negedge clk);
    rst_n = rst; s_valid = v; s_data = d; train_req = r;
    #1;
    inTrain  = (trainLeft > 0);
    expReady = !inTrain && !r;
    sawReady = s_ready;
    sawTrain = train_active;
    if (rst) begin
      checkOutput("s_ready", {7'b0, s_ready}, {7'b0, expReady});
      checkOutput("train_active", {7'b0, train_active}, {7'b0, inTrain});
    end
    @(posedge clk);
    if (!rst) begin
      trainLeft = TC; expQ = 5'h00; prbsModel = 7'h7F;
    end else if (inTrain) begin
      expQ = {1'b0, trainWord()};
      prbsModel = r ? 7'h7F : {prbsModel[5:0], prbsModel[6] ^ prbsModel[5]};
      trainLeft = r ? TC : trainLeft - 1;
    end else begin
      expQ = (v && expReady) ? {1'b1, d} : 5'h00;
      if (r) begin
        trainLeft = TC; prbsModel = 7'h7F;
      end
    end
    #1;
    checkOutput("q_p", {3'b0, output_q_p}, {3'b0, expQ});
    checkOutput("q_n", {3'b0, output_q_n}, {3'b0, ~expQ});
    checkOutput("clk_pair", {6'b0, output_clk_p, output_clk_n}, 8'h01);
  endtask

  // Idle until training ends; n = number of cycles seen with train_active high.
  task automatic runUntilActive(output int n);
    logic rd, tr;
    bit done = 0;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, rd, tr);
      if (!tr) begin
        done = 1;
        break;
      end
      n++;
    end
    if (!done) checkOutput("train_timeout", 8'd1, 8'd0);
  endtask

  initial begin
    logic rd, tr;
    int   n;

    vecs[0] = '{valid: 1'b1, data: 4'h3, req: 1'b0, q: 5'h13, ready: 1'b1};
    vecs[1] = '{valid: 1'b1, data: 4'h5, req: 1'b0, q: 5'h15, ready: 1'b1};
    vecs[2] = '{valid: 1'b1, data: 4'hC, req: 1'b0, q: 5'h1C, ready: 1'b1};
    vecs[3] = '{valid: 1'b0, data: 4'h0, req: 1'b0, q: 5'h00, ready: 1'b1};
    vecs[4] = '{valid: 1'b1, data: 4'h9, req: 1'b1, q: 5'h00, ready: 1'b0};

    // Reset, then training length after release.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, rd, tr);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, rd, tr);
    checkOutput("reset_q", {3'b0, output_q_p}, 8'h00);
    runUntilActive(n);
    checkOutput("train_len_reset", 8'(n), 8'd64);
    checkOutput("active_idle_q", {3'b0, output_q_p}, 8'h00);

    // Burst, idle, then a train_req while a word is offered.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].valid, vecs[i].data, vecs[i].req, rd, tr);
      checkOutput("vec_ready", {7'b0, rd}, {7'b0, vecs[i].ready});
      checkOutput("vec_q", {3'b0, output_q_p}, {3'b0, vecs[i].q});
    end
    runUntilActive(n);
    checkOutput("train_len_req", 8'(n), 8'd64);
    checkOutput("post_train_idle_q", {3'b0, output_q_p}, 8'h00);
    applyStimulus(1'b1, 1'b1, 4'h9, 1'b0, rd, tr);
    checkOutput("held_word_q", {3'b0, output_q_p}, 8'h19);

    // Restart training at its 30th cycle.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, rd, tr);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, (n == 29), rd, tr);
      if (!tr) break;
      n++;
    end
    checkOutput("train_len_restart", 8'(n), 8'd94);

    // Reset in the middle of a burst.
    applyStimulus(1'b1, 1'b1, 4'h6, 1'b0, rd, tr);
    applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, rd, tr);
    checkOutput("midburst_reset_q", {3'b0, output_q_p}, 8'h00);
    runUntilActive(n);
    checkOutput("train_len_midreset", 8'(n), 8'd64);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
                    4'($urandom), ($urandom_range(0, 79) == 0), rd, tr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
